mem_responder: RTL and testbench

//  Memory-side responder for the 16-bit multicycle CPU's memory request

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_lat_counter.sv | 36 +++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder word-memory responder.
// Holds the FSM state encoding, word/counter widths and the latency-load helper.
package mem_responder_pkg;

  localparam int WORD_W    = 16;
  localparam int LATENCY_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Counter preload for a given latency; the zero cycle itself supplies the last tick.
  function automatic logic [LATENCY_W-1:0] latency_load(input int latency);
    return LATENCY_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_responder_lat_counter.sv
// Loadable down-counter that times the mem_responder access latency.
// Saturates at zero and reports the zero condition combinationally.
module mem_responder_lat_counter
  import mem_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [LATENCY_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [LATENCY_W-1:0] count_q;
  logic [LATENCY_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - LATENCY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services held readM/writeM requests after a fixed latency.
// Optional MEM_RESP_ADDR_CHECK_EN adds addr_err and blocks out-of-range accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readM,
  input  logic              writeM,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              ready,
`ifdef MEM_RESP_ADDR_CHECK_EN
  output logic              addr_err,
`endif
  output logic              busy
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [LATENCY_W-1:0] LOAD_VAL = latency_load(LATENCY);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              ready_q, ready_d;

  logic              req;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              mem_we;
  logic              addr_bad;

  logic [WORD_W-1:0] mem_array [DEPTH];

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic addr_bad_q, addr_bad_d;
  logic addr_err_q, addr_err_d;
  assign addr_bad = addr_bad_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[WORD_W-1:AW];
  assign addr_bad       = 1'b0;
`endif

  assign req = readM | writeM;

  mem_responder_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mem_we     = 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
    addr_bad_d = addr_bad_q;
    addr_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d      = address[AW-1:0];
          wdata_d    = data_in;
          is_write_d = writeM;
          cnt_load   = 1'b1;
          state_d    = BUSY;
`ifdef MEM_RESP_ADDR_CHECK_EN
          addr_bad_d = |address[WORD_W-1:AW];
`endif
        end
      end
      BUSY: begin
        // A dropped request aborts before the access can take effect.
        if (!req) begin
          state_d = IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          ready_d = 1'b1;
          state_d = RELEASE;
          if (is_write_q) begin
            mem_we = !addr_bad;
          end else begin
            data_out_d = addr_bad ? '0 : mem_array[idx_q];
          end
`ifdef MEM_RESP_ADDR_CHECK_EN
          addr_err_d = addr_bad_q;
`endif
        end
      end
      RELEASE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
      addr_bad_q <= 1'b0;
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
`ifdef MEM_RESP_ADDR_CHECK_EN
      addr_bad_q <= addr_bad_d;
      addr_err_q <= addr_err_d;
`endif
    end
  end

  // Storage is deliberately left out of reset so completed writes survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign busy     = (state_q == BUSY) || (state_q == RELEASE);
`ifdef MEM_RESP_ADDR_CHECK_EN
  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against an array-based memory model.
// Covers directed cases plus random traffic, and latency 1/15 instances.
module tb_mem_responder;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic        readM, writeM;
  logic [15:0] address, data_in;
  logic [15:0] data_out;
  logic        ready, busy;

  logic        lat_rd, lat_wr;
  logic [15:0] lat_addr, lat_din;
  logic [15:0] data_out_l1, data_out_l15;
  logic        ready_l1, ready_l15, busy_l1, busy_l15;

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic addr_err, unused_err_l1, unused_err_l15;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem_m [DEPTH];
  logic [15:0] dout_m;

  mem_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .readM(readM), .writeM(writeM),
    .address(address), .data_in(data_in), .data_out(data_out),
    .ready(ready),
`ifdef MEM_RESP_ADDR_CHECK_EN
    .addr_err(addr_err),
`endif
    .busy(busy)
  );

  mem_responder #(.AW(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .readM(lat_rd), .writeM(lat_wr),
    .address(lat_addr), .data_in(lat_din), .data_out(data_out_l1),
    .ready(ready_l1),
`ifdef MEM_RESP_ADDR_CHECK_EN
    .addr_err(unused_err_l1),
`endif
    .busy(busy_l1)
  );

  mem_responder #(.AW(AW), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .readM(lat_rd), .writeM(lat_wr),
    .address(lat_addr), .data_in(lat_din), .data_out(data_out_l15),
    .ready(ready_l15),
`ifdef MEM_RESP_ADDR_CHECK_EN
    .addr_err(unused_err_l15),
`endif
    .busy(busy_l15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one completed access, from the address/op rules.
  task automatic model_complete(input logic wr, input logic [15:0] a,
                                input logic [15:0] d, output logic exp_err);
    int  idx;
    logic bad;
    idx = int'(a) % DEPTH;
    bad = 1'b0;
`ifdef MEM_RESP_ADDR_CHECK_EN
    bad = (int'(a) >= DEPTH);
`endif
    exp_err = bad;
    if (wr) begin
      if (!bad) mem_m[idx] = d;
    end else begin
      dout_m = bad ? 16'h0000 : mem_m[idx];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full request: drive, wait for ready, hold, release.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a,
                                input logic [15:0] d, input int hold);
    int   cyc;
    int   pulses;
    bit   seen;
    logic exp_err;
    readM = rd; writeM = wr; address = a; data_in = d;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        address = 16'($urandom);
        data_in = 16'($urandom);
      end
      if (ready) seen = 1;
    end
    check_output("ready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_output("latency", 32'(cyc - 1), 32'(LAT));
      model_complete(wr, a, d, exp_err);
      check_output("data_out", 32'(data_out), 32'(dout_m));
`ifdef MEM_RESP_ADDR_CHECK_EN
      check_output("addr_err", 32'(addr_err), 32'(exp_err));
`endif
    end
    pulses = 0;
    for (int i = 0; i <= hold; i++) begin
      tick();
      if (ready) pulses++;
`ifdef MEM_RESP_ADDR_CHECK_EN
      if (addr_err) pulses++;
`endif
    end
    check_output("extra_pulses", 32'(pulses), 32'd0);
    check_output("busy_held", 32'(busy), 32'd1);
    readM = 1'b0; writeM = 1'b0;
    tick();
    check_output("busy_released", 32'(busy), 32'd0);
  endtask

  // Write request dropped one cycle after accept must leave no trace.
  task automatic abort_write(input logic [15:0] a, input logic [15:0] d);
    int pulses;
    readM = 1'b0; writeM = 1'b1; address = a; data_in = d;
    tick();
    check_output("abort_busy", 32'(busy), 32'd1);
    writeM = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready) pulses++;
    end
    check_output("abort_no_ready", 32'(pulses), 32'd0);
    check_output("abort_idle", 32'(busy), 32'd0);
    check_output("abort_dout", 32'(data_out), 32'(dout_m));
  endtask

  task automatic lat_pair(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_dout);
    int c1, c15;
    lat_rd = rd; lat_wr = wr; lat_addr = a; lat_din = d;
    c1 = 0; c15 = 0;
    for (int i = 1; i <= 40 && (c1 == 0 || c15 == 0); i++) begin
      tick();
      if (ready_l1 && c1 == 0) c1 = i;
      if (ready_l15 && c15 == 0) c15 = i;
    end
    check_output("lat1_timing", 32'(c1 - 1), 32'd1);
    check_output("lat15_timing", 32'(c15 - 1), 32'd15);
    check_output("lat1_dout", 32'(data_out_l1), 32'(exp_dout));
    check_output("lat15_dout", 32'(data_out_l15), 32'(exp_dout));
    lat_rd = 1'b0; lat_wr = 1'b0;
    tick();
    check_output("lat_idle", 32'({busy_l1, busy_l15}), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] a;
    int          op;
    reset = 1'b1;
    readM = 0; writeM = 0; address = 0; data_in = 0;
    lat_rd = 0; lat_wr = 0; lat_addr = 0; lat_din = 0;
    dout_m = 16'h0000;
    tick();
    tick();
    check_output("reset_ready", 32'(ready), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_dout", 32'(data_out), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, 16'(i), 16'($urandom), 0);

    // Write then read back.
    apply_stimulus(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0);
    apply_stimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 0);
    check_output("beef_readback", 32'(data_out), 32'h0000BEEF);

    // Held read: one pulse only, next accept right after the drop.
    apply_stimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 10);
    apply_stimulus(1'b1, 1'b0, 16'h0013, 16'h0000, 0);

    apply_stimulus(1'b0, 1'b1, 16'h0005, 16'h2222, 0);
    abort_write(16'h0005, 16'h1111);
    apply_stimulus(1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    check_output("abort_readback", 32'(data_out), 32'h00002222);

    // Index wrap through the upper address bits.
    apply_stimulus(1'b0, 1'b1, 16'h0103, 16'hA5A5, 0);
    apply_stimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 0);

    // Async reset in the middle of a write.
    readM = 1'b0; writeM = 1'b1; address = 16'h0020; data_in = 16'h7777;
    tick();
    check_output("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("rst_async_busy", 32'(busy), 32'd0);
    check_output("rst_async_ready", 32'(ready), 32'd0);
    check_output("rst_async_dout", 32'(data_out), 32'd0);
    dout_m = 16'h0000;
    writeM = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 0);

    // Both strobes high means write; data_out must hold.
    apply_stimulus(1'b1, 1'b1, 16'h0001, 16'h0F0F, 1);
    apply_stimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 0);

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 9));
      d  = 16'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, DEPTH - 1)) : 16'($urandom);
      if (op <= 3)      apply_stimulus(1'b1, 1'b0, a, d, int'($urandom_range(0, 3)));
      else if (op <= 7) apply_stimulus(1'b0, 1'b1, a, d, int'($urandom_range(0, 3)));
      else if (op == 8) apply_stimulus(1'b1, 1'b1, a, d, int'($urandom_range(0, 3)));
      else              abort_write(a, d);
    end

    d = 16'($urandom);
    lat_pair(1'b1, 1'b1, 16'h0042, d, 16'h0000);
    lat_pair(1'b1, 1'b0, 16'h0042, 16'h0000, d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
